// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux
//   Time-multiplexed scanner for a common-anode multi-digit 7-segment display.
//   A shadow register holds a packed BCD word; a prescaler steps through the
//   digits every SCAN_DIV cycles.  Each digit change inserts one dead cycle
//   with all anodes off to suppress ghosting.  Digits holding an invalid
//   nibble (> 9) are blanked and flag err.
//
//   Optional feature: define SEG7_SCAN_LZB_EN to enable leading-zero blanking
//   (zero digits above the most significant non-zero digit stay dark; digit 0
//   is always shown, and invalid nibbles count as non-zero).
//
// Parameters
//   DIGITS    number of display digits (2..8)
//   SCAN_DIV  clock cycles each digit is selected (>= 2)
// Ports
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   bcd_in     packed BCD digits, [3:0] is digit 0
//   load       capture bcd_in into the shadow register
//   digit_bcd  BCD of the selected digit (to the decoder B input)
//   an         active-low digit enables, at most one bit low
//   digit_idx  index of the selected digit
//   err        shadow register holds at least one nibble > 9
module seg7_scan_mux #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4*DIGITS-1:0] bcd_in,
  input  logic                load,
  output logic [3:0]          digit_bcd,
  output logic [DIGITS-1:0]   an,
  output logic [2:0]          digit_idx,
  output logic                err
);

  localparam int             PW   = $clog2(SCAN_DIV);
  localparam logic [PW-1:0]  PMAX = PW'(SCAN_DIV - 1);
  localparam logic [2:0]     IMAX = 3'(DIGITS - 1);

  logic [4*DIGITS-1:0] shadow;
  logic [PW-1:0]       pcnt;
  logic [2:0]          idx;
  logic                dead;
  logic                run;
  logic                tick;

  logic [DIGITS-1:0]   invalid;
  logic [DIGITS-1:0]   blank;
  logic                sel_blank;

  assign tick = (pcnt == PMAX);

  // The reset period counts as digit 0's dark period: the first tick after
  // reset enables digit 0 instead of advancing, so the scan starts at digit 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow <= '0;
      pcnt   <= '0;
      idx    <= '0;
      dead   <= 1'b1;
      run    <= 1'b0;
    end else begin
      if (load)
        shadow <= bcd_in;
      pcnt <= tick ? '0 : pcnt + 1'b1;
      if (tick) begin
        if (run) begin
          idx  <= (idx == IMAX) ? 3'd0 : idx + 3'd1;
          dead <= 1'b1;
        end else begin
          run  <= 1'b1;
          dead <= 1'b0;
        end
      end else if (run) begin
        dead <= 1'b0;
      end
    end
  end

  // Per-digit blanking, decoded from the shadow register only.
`ifdef SEG7_SCAN_LZB_EN
  logic seen;
`endif
  always_comb begin
    invalid = '0;
    blank   = '0;
    for (int i = 0; i < DIGITS; i++)
      invalid[i] = (shadow[4*i +: 4] > 4'd9);
`ifdef SEG7_SCAN_LZB_EN
    // Scan from the top digit down; a digit is a leading zero while no
    // non-zero nibble has been seen at or above it.
    seen = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen     = seen | (shadow[4*i +: 4] != 4'd0);
      blank[i] = invalid[i] | ((i != 0) & ~seen);
    end
`else
    blank = invalid;
`endif
  end

  // Output decode: select the current digit and its enable.
  always_comb begin
    digit_bcd = 4'd0;
    sel_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == 3'(i)) begin
        digit_bcd = shadow[4*i +: 4];
        sel_blank = blank[i];
      end
    end
    for (int i = 0; i < DIGITS; i++)
      an[i] = ~(~dead & ~sel_blank & (idx == 3'(i)));
  end

  assign digit_idx = idx;
  assign err       = |invalid;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Testbench for seg7_scan_mux with DIGITS=4, SCAN_DIV=4.
// Directed stimulus pushes the hand-computed expected outputs for the cycle
// following each clock edge into a queue; a monitor on the falling edge pops
// and compares them against the DUT outputs.
module tb_seg7_scan_mux;

  localparam logic [3:0] AN_OFF = 4'b1111;
  localparam logic [3:0] AN0    = 4'b1110;
  localparam logic [3:0] AN1    = 4'b1101;
  localparam logic [3:0] AN2    = 4'b1011;
  localparam logic [3:0] AN3    = 4'b0111;
`ifdef SEG7_SCAN_LZB_EN
  localparam logic [3:0] LZ_AN2 = AN_OFF;
  localparam logic [3:0] LZ_AN3 = AN_OFF;
`else
  localparam logic [3:0] LZ_AN2 = AN2;
  localparam logic [3:0] LZ_AN3 = AN3;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] bcd_in;
  logic        load;
  logic [3:0]  digit_bcd;
  logic [3:0]  an;
  logic [2:0]  digit_idx;
  logic        err;

  seg7_scan_mux #(.DIGITS(4), .SCAN_DIV(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bcd_in    (bcd_in),
    .load      (load),
    .digit_bcd (digit_bcd),
    .an        (an),
    .digit_idx (digit_idx),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  an;
    logic [3:0]  bcd;
    logic [2:0]  idx;
    logic        err;
    logic [7:0]  scn;
    logic [15:0] stp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   scn    = 0;
  int   stp    = 0;

  // Apply inputs for the next edge, then queue the outputs expected after it.
  task automatic step(input logic r, input logic ld, input logic [15:0] v,
                      input logic [3:0] ea, input logic [3:0] eb,
                      input logic [2:0] ei, input logic ee);
    exp_t e;
    rst_n  = r;
    load   = ld;
    bcd_in = v;
    @(posedge clk);
    #1;
    stp++;
    e.an = ea; e.bcd = eb; e.idx = ei; e.err = ee;
    e.scn = 8'(scn); e.stp = 16'(stp);
    q.push_back(e);
  endtask

  task automatic idle(input logic [3:0] ea, input logic [3:0] eb,
                      input logic [2:0] ei, input logic ee);
    step(1'b1, 1'b0, 16'h0, ea, eb, ei, ee);
  endtask

  task automatic ld(input logic [15:0] v, input logic [3:0] ea,
                    input logic [3:0] eb, input logic [2:0] ei, input logic ee);
    step(1'b1, 1'b1, v, ea, eb, ei, ee);
  endtask

  task automatic do_reset(input int n);
    scn = n;
    stp = 0;
    step(1'b0, 1'b0, 16'h0, AN_OFF, 4'd0, 3'd0, 1'b0);
    step(1'b0, 1'b1, 16'h9999, AN_OFF, 4'd0, 3'd0, 1'b0);
  endtask

  // Monitor: compare one queued expectation per cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (an !== e.an || digit_bcd !== e.bcd || digit_idx !== e.idx || err !== e.err) begin
          errors++;
          $display("FAIL scn%0d step%0d: got an=%b bcd=%h idx=%0d err=%b, expected an=%b bcd=%h idx=%0d err=%b",
                   e.scn, e.stp, an, digit_bcd, digit_idx, err, e.an, e.bcd, e.idx, e.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; load = 1'b0; bcd_in = 16'h0;

    // 1: reset then idle, digit 0 dark for the first scan period.
    do_reset(1);
    for (int k = 0; k < 3; k++) idle(AN_OFF, 4'd0, 3'd0, 1'b0);
    for (int k = 0; k < 4; k++) idle(AN0, 4'd0, 3'd0, 1'b0);
    idle(AN_OFF, 4'd0, 3'd1, 1'b0);

    // 2: full scan of 1234.
    do_reset(2);
    ld(16'h1234, AN_OFF, 4'd4, 3'd0, 1'b0);
    for (int k = 0; k < 2; k++) idle(AN_OFF, 4'd4, 3'd0, 1'b0);
    for (int k = 0; k < 4; k++) idle(AN0, 4'd4, 3'd0, 1'b0);
    idle(AN_OFF, 4'd3, 3'd1, 1'b0);
    for (int k = 0; k < 3; k++) idle(AN1, 4'd3, 3'd1, 1'b0);
    idle(AN_OFF, 4'd2, 3'd2, 1'b0);
    for (int k = 0; k < 3; k++) idle(AN2, 4'd2, 3'd2, 1'b0);
    idle(AN_OFF, 4'd1, 3'd3, 1'b0);
    for (int k = 0; k < 3; k++) idle(AN3, 4'd1, 3'd3, 1'b0);
    idle(AN_OFF, 4'd4, 3'd0, 1'b0);
    idle(AN0, 4'd4, 3'd0, 1'b0);

    // 3: invalid nibble in digit 1, then corrected mid-period.
    do_reset(3);
    ld(16'h12A4, AN_OFF, 4'd4, 3'd0, 1'b1);
    for (int k = 0; k < 2; k++) idle(AN_OFF, 4'd4, 3'd0, 1'b1);
    for (int k = 0; k < 4; k++) idle(AN0, 4'd4, 3'd0, 1'b1);
    idle(AN_OFF, 4'hA, 3'd1, 1'b1);
    idle(AN_OFF, 4'hA, 3'd1, 1'b1);
    ld(16'h1204, AN1, 4'd0, 3'd1, 1'b0);
    idle(AN1, 4'd0, 3'd1, 1'b0);
    idle(AN_OFF, 4'd2, 3'd2, 1'b0);
    idle(AN2, 4'd2, 3'd2, 1'b0);

    // 4: 0050, leading zeros shown or blanked depending on build.
    do_reset(4);
    ld(16'h0050, AN_OFF, 4'd0, 3'd0, 1'b0);
    for (int k = 0; k < 2; k++) idle(AN_OFF, 4'd0, 3'd0, 1'b0);
    for (int k = 0; k < 4; k++) idle(AN0, 4'd0, 3'd0, 1'b0);
    idle(AN_OFF, 4'd5, 3'd1, 1'b0);
    for (int k = 0; k < 3; k++) idle(AN1, 4'd5, 3'd1, 1'b0);
    idle(AN_OFF, 4'd0, 3'd2, 1'b0);
    for (int k = 0; k < 3; k++) idle(LZ_AN2, 4'd0, 3'd2, 1'b0);
    idle(AN_OFF, 4'd0, 3'd3, 1'b0);
    idle(LZ_AN3, 4'd0, 3'd3, 1'b0);

    // 5: load on the tick edge, next digit shows new data at once.
    do_reset(5);
    ld(16'h1234, AN_OFF, 4'd4, 3'd0, 1'b0);
    for (int k = 0; k < 2; k++) idle(AN_OFF, 4'd4, 3'd0, 1'b0);
    for (int k = 0; k < 4; k++) idle(AN0, 4'd4, 3'd0, 1'b0);
    ld(16'h5678, AN_OFF, 4'd7, 3'd1, 1'b0);
    idle(AN1, 4'd7, 3'd1, 1'b0);
    idle(AN1, 4'd7, 3'd1, 1'b0);

    // 6: one-cycle reset while idx=2 clears everything and restarts.
    do_reset(6);
    ld(16'h1234, AN_OFF, 4'd4, 3'd0, 1'b0);
    for (int k = 0; k < 2; k++) idle(AN_OFF, 4'd4, 3'd0, 1'b0);
    for (int k = 0; k < 4; k++) idle(AN0, 4'd4, 3'd0, 1'b0);
    idle(AN_OFF, 4'd3, 3'd1, 1'b0);
    for (int k = 0; k < 3; k++) idle(AN1, 4'd3, 3'd1, 1'b0);
    idle(AN_OFF, 4'd2, 3'd2, 1'b0);
    idle(AN2, 4'd2, 3'd2, 1'b0);
    step(1'b0, 1'b1, 16'h9876, AN_OFF, 4'd0, 3'd0, 1'b0);
    for (int k = 0; k < 3; k++) idle(AN_OFF, 4'd0, 3'd0, 1'b0);
    idle(AN0, 4'd0, 3'd0, 1'b0);

    // Drain the scoreboard, bounded.
    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
